// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM core.
//   Main FSM (one state per cycle), ALU decoder and conditional-execution logic.
//   Optional build macro: MC_CMP_EN enables CMP decode (funct[4:1]=1010, S=1).
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   Instr[31:12]      cond, op, funct, Rd from the instruction register
//   ALUFlags[3:0]     {N,Z,C,V} from the datapath ALU
//   PCWrite, MemWrite, RegWrite, IRWrite   write strobes (gated by condition)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl   datapath muxes
module mc_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUControl
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q, flags_d;     // {N,Z,C,V}
    logic        cond_ex_q, cond_ex_d;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        s_bit;
    logic [3:0]  rd;
    logic        is_cmp;
    logic        unused_rn;

    logic        next_pc, branch, reg_w, mem_w, ir_write, alu_op;
    logic [1:0]  alu_ctrl, flag_w;
    logic        pcs;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign s_bit     = Instr[20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

`ifdef MC_CMP_EN
    assign is_cmp = (op == 2'b00) && (funct[4:1] == 4'b1010) && s_bit;
`else
    assign is_cmp = 1'b0;
`endif

    // Main FSM: next state and per-state control
    always_comb begin
        state_d   = state_q;
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_write  = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            StFetch: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;   // undefined op retires as a NOP
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                reg_w     = 1'b1;
                ResultSrc = 2'b01;
                state_d   = StFetch;
            end
            StMemWr: begin
                mem_w   = 1'b1;
                AdrSrc  = 1'b1;
                state_d = StFetch;
            end
            StExecR: begin
                alu_op  = 1'b1;
                state_d = StAluWb;
            end
            StExecI: begin
                alu_op  = 1'b1;
                ALUSrcB = 2'b01;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_w   = !is_cmp;            // CMP only sets flags
                state_d = StFetch;
            end
            StBranch: begin
                branch    = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // ALU decoder
    always_comb begin
        alu_ctrl = 2'b00;
        flag_w   = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: alu_ctrl = 2'b00;
                4'b0010: alu_ctrl = 2'b01;
                4'b0000: alu_ctrl = 2'b10;
                4'b1100: alu_ctrl = 2'b11;
                4'b1010: alu_ctrl = is_cmp ? 2'b01 : 2'b00;
                default: alu_ctrl = 2'b00;
            endcase
            flag_w = {s_bit, s_bit & ((alu_ctrl == 2'b00) || (alu_ctrl == 2'b01))};
        end
    end

    // Condition check against the flags as they stand before this instruction
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex_d = 1'b0;
        case (cond)
            4'b0000: cond_ex_d = z;
            4'b0001: cond_ex_d = !z;
            4'b0010: cond_ex_d = c;
            4'b0011: cond_ex_d = !c;
            4'b0100: cond_ex_d = n;
            4'b0101: cond_ex_d = !n;
            4'b0110: cond_ex_d = v;
            4'b0111: cond_ex_d = !v;
            4'b1000: cond_ex_d = c & !z;
            4'b1001: cond_ex_d = !(c & !z);
            4'b1010: cond_ex_d = (n == v);
            4'b1011: cond_ex_d = (n != v);
            4'b1100: cond_ex_d = !z & (n == v);
            4'b1101: cond_ex_d = !(!z & (n == v));
            default: cond_ex_d = 1'b1;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] && cond_ex_d) flags_d[3:2] = ALUFlags[3:2];
        if (flag_w[0] && cond_ex_d) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Write gating; strobes held low while reset is asserted
    assign pcs        = branch | (reg_w & (rd == 4'd15));
    assign PCWrite    = !reset & (next_pc | (pcs & cond_ex_q));
    assign RegWrite   = !reset & reg_w & cond_ex_q;
    assign MemWrite   = !reset & mem_w & cond_ex_q;
    assign IRWrite    = !reset & ir_write;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign ImmSrc     = op;
    assign ALUControl = alu_ctrl;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
//   Each cycle compares the packed control-output vector against hand-computed values.
//   Honours MC_CMP_EN for the CMP expectations.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, mem_write, reg_write, ir_write, adr_src;
    logic [1:0]  reg_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (instr[31:12]),
        .ALUFlags   (alu_flags),
        .PCWrite    (pc_write),
        .MemWrite   (mem_write),
        .RegWrite   (reg_write),
        .IRWrite    (ir_write),
        .AdrSrc     (adr_src),
        .RegSrc     (reg_src),
        .ALUSrcA    (alu_src_a),
        .ALUSrcB    (alu_src_b),
        .ResultSrc  (result_src),
        .ImmSrc     (imm_src),
        .ALUControl (alu_control)
    );

    // Packing order: pcw mw rw irw adr regsrc srca srcb res imm aluc
    function automatic logic [16:0] cv(input logic pcw, input logic mw, input logic rw,
                                       input logic irw, input logic adr,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] ac);
        return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, ac};
    endfunction

    function automatic logic [16:0] outs();
        return {pc_write, mem_write, reg_write, ir_write, adr_src, reg_src,
                alu_src_a, alu_src_b, result_src, imm_src, alu_control};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered #1 after an edge with the DUT in FETCH; leaves #1 after the edge ending cycle n-1.
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] fl,
                             input int n, input logic [16:0] e0, input logic [16:0] e1,
                             input logic [16:0] e2, input logic [16:0] e3,
                             input logic [16:0] e4);
        logic [16:0] exp_v [5];
        exp_v = '{e0, e1, e2, e3, e4};
        instr     = ins;
        alu_flags = fl;
        #1;
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s.c%0d", tag, i), {15'd0, outs()}, {15'd0, exp_v[i]});
            @(posedge clk);
            #1;
        end
    endtask

    // Common vectors
    logic [16:0] f_dp, d_dp, f_mem, d_mem, adr_v, f_br, d_br, br_t, br_n, wb_1, wb_0;
    logic [16:0] z;
    logic        cmp_en;
    logic [1:0]  cmp_ac;

    initial begin
        z     = '0;
        f_dp  = cv(1, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
        d_dp  = cv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00);
        f_mem = cv(1, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);
        d_mem = cv(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);
        adr_v = cv(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        f_br  = cv(1, 0, 0, 1, 0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00);
        d_br  = cv(0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00);
        br_t  = cv(1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00);
        br_n  = cv(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00);
        wb_1  = cv(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        wb_0  = cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
`ifdef MC_CMP_EN
        cmp_en = 1'b1;
        cmp_ac = 2'b01;
`else
        cmp_en = 1'b0;
        cmp_ac = 2'b00;
`endif

        reset     = 1'b1;
        instr     = 32'h0;
        alu_flags = 4'h0;
        @(posedge clk);
        #1;
        // In reset: FETCH muxes, all strobes low
        check_eq("rst_hold", {15'd0, outs()},
                 {15'd0, cv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00)});
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD R2,R0,R1
        run_instr("add", 32'hE0802001, 4'h0, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), wb_1, z);
        // ORR R2,R0,R1
        run_instr("orr", 32'hE1802001, 4'h0, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11), wb_1, z);
        // LDR R3,[R0,#4]
        run_instr("ldr", 32'hE5903004, 4'h0, 5, f_mem, d_mem, adr_v,
                  cv(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00),
                  cv(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00));
        // STR R3,[R0,#8]
        run_instr("str", 32'hE5803008, 4'h0, 4, f_mem, d_mem, adr_v,
                  cv(0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), z);
        // SUBS R1,R1,#1 with Z set
        run_instr("subs_z", 32'hE2511001, 4'b0100, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01), wb_1, z);
        // BEQ taken
        run_instr("beq_t", 32'h0A000002, 4'h0, 3, f_br, d_br, br_t, z, z);
        // ADDNE with Z=1: no register write
        run_instr("addne", 32'h10802001, 4'h0, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), wb_0, z);

        // STR aborted by reset in MEMWR
        run_instr("str_rst", 32'hE5803008, 4'h0, 3, f_mem, d_mem, adr_v, z, z);
        reset = 1'b1;
        #1;
        check_eq("memwr_rst", {15'd0, outs()},
                 {15'd0, cv(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00)});
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Flags cleared by reset: BEQ not taken, BNE taken
        run_instr("beq_rst", 32'h0A000002, 4'h0, 3, f_br, d_br, br_n, z, z);
        run_instr("bne_rst", 32'h1A000002, 4'h0, 3, f_br, d_br, br_t, z, z);

        // SUBS setting Z, then SUBS clearing it: BEQ falls through
        run_instr("subs_z2", 32'hE2511001, 4'b0100, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01), wb_1, z);
        run_instr("subs_nz", 32'hE2511001, 4'b0000, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01), wb_1, z);
        run_instr("beq_n", 32'h0A000002, 4'h0, 3, f_br, d_br, br_n, z, z);

        // Undefined op 11: FETCH, DECODE, back to FETCH
        run_instr("undef", 32'hEC000000, 4'h0, 2,
                  cv(1, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00),
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00), z, z, z);

        // CMP R1,#5 (add with S when CMP decode is off); flags load either way
        run_instr("cmp", 32'hE3510005, 4'b0100, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, cmp_ac),
                  cv(0, 0, !cmp_en, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), z);
        run_instr("beq_cmp", 32'h0A000002, 4'h0, 3, f_br, d_br, br_t, z, z);

        // ADD PC,R0,R1: write to R15 also strobes PCWrite
        run_instr("add_pc", 32'hE080F001, 4'h0, 4, f_dp, d_dp,
                  cv(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00),
                  cv(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // Back in FETCH afterwards
        check_eq("final_fetch", {15'd0, outs()}, {15'd0, f_dp});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
